// File: rtl/datain_pkt_rx_if.sv
// datain_pkt_rx_if: datain byte-stream input plus the committed-packet output stream and status pulses.
interface datain_pkt_rx_if;
    logic       packet_valid;
    logic [7:0] data_in;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_sop;
    logic       dout_eop;
    logic       pkt_ok;
    logic       parity_err;
    logic       len_err;
    logic       ovf_err;
    logic       busy;
    modport master (
        output packet_valid, data_in, dout_ready,
        input  dout, dout_valid, dout_sop, dout_eop, pkt_ok, parity_err, len_err, ovf_err, busy
    );
    modport slave (
        input  packet_valid, data_in, dout_ready,
        output dout, dout_valid, dout_sop, dout_eop, pkt_ok, parity_err, len_err, ovf_err, busy
    );
endinterface

// File: rtl/datain_pkt_rx.sv
// datain_pkt_rx: parses datain packets, checks length/parity, and releases only good packets
// from a FIFO that is written speculatively and committed or rewound at packet end.
module datain_pkt_rx #(
    parameter int DEPTH = 64
) (
    input logic clk,
    input logic rst,
    datain_pkt_rx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, PAYLOAD, PARITY, END, DROP} state_t;
    state_t state, state_n;
    logic [AW:0] rd, wr_spec, wr_cmt, wr_spec_n, wr_cmt_n;
    logic [7:0] acc, acc_n;
    logic [5:0] cnt, cnt_n, hdr_len;
    logic par_ok, par_ok_n, sop_flag, we, weop, rewind, take;
    logic ok_n, perr_n, lerr_n, oerr_n;
    logic [AW+1:0] need;
    logic [8:0] mem [DEPTH];
    logic [8:0] head;

    assign hdr_len = bus.data_in[7:2];
    // entries the packet needs (header + payload) on top of what is already buffered
    assign need = (AW+2)'(wr_spec - rd) + (AW+2)'(hdr_len) + (AW+2)'(1);
    assign head = mem[rd[AW-1:0]];
    assign take = bus.dout_valid & bus.dout_ready;
    assign bus.dout_valid = rd != wr_cmt;
    assign bus.dout = bus.dout_valid ? head[7:0] : 8'd0;
    assign bus.dout_eop = bus.dout_valid & head[8];
    assign bus.dout_sop = bus.dout_valid & sop_flag;
    assign bus.busy = state != IDLE;

    always_comb begin
        state_n = state;
        acc_n = acc;
        cnt_n = cnt;
        par_ok_n = par_ok;
        wr_cmt_n = wr_cmt;
        we = 1'b0;
        weop = 1'b0;
        rewind = 1'b0;
        ok_n = 1'b0;
        perr_n = 1'b0;
        lerr_n = 1'b0;
        oerr_n = 1'b0;
        case (state)
            IDLE: if (bus.packet_valid) begin
                if (hdr_len == 6'd0) begin
                    lerr_n = 1'b1;
                    state_n = DROP;
                end else if (need > (AW+2)'(DEPTH)) begin
                    oerr_n = 1'b1;
                    state_n = DROP;
                end else begin
                    we = 1'b1;
                    acc_n = bus.data_in;
                    cnt_n = hdr_len;
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: if (bus.packet_valid) begin
                we = 1'b1;
                weop = cnt == 6'd1;
                acc_n = acc ^ bus.data_in;
                cnt_n = cnt - 6'd1;
                state_n = cnt == 6'd1 ? PARITY : PAYLOAD;
            end else begin
                lerr_n = 1'b1;
                rewind = 1'b1;
                state_n = IDLE;
            end
            PARITY: if (bus.packet_valid) begin
                par_ok_n = bus.data_in == acc;
                state_n = END;
            end else begin
                lerr_n = 1'b1;
                rewind = 1'b1;
                state_n = IDLE;
            end
            END: if (bus.packet_valid) begin
                lerr_n = 1'b1;
                rewind = 1'b1;
                state_n = DROP;
            end else begin
                ok_n = par_ok;
                perr_n = !par_ok;
                rewind = !par_ok;
                wr_cmt_n = par_ok ? wr_spec : wr_cmt;
                state_n = IDLE;
            end
            DROP: state_n = bus.packet_valid ? DROP : IDLE;
            default: state_n = IDLE;
        endcase
        wr_spec_n = rewind ? wr_cmt : wr_spec + (AW+1)'(we);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rd <= '0;
            wr_spec <= '0;
            wr_cmt <= '0;
            acc <= '0;
            cnt <= '0;
            par_ok <= 1'b0;
            sop_flag <= 1'b1;
            bus.pkt_ok <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.len_err <= 1'b0;
            bus.ovf_err <= 1'b0;
        end else begin
            state <= state_n;
            rd <= rd + (AW+1)'(take);
            wr_spec <= wr_spec_n;
            wr_cmt <= wr_cmt_n;
            acc <= acc_n;
            cnt <= cnt_n;
            par_ok <= par_ok_n;
            sop_flag <= take ? head[8] : sop_flag;
            bus.pkt_ok <= ok_n;
            bus.parity_err <= perr_n;
            bus.len_err <= lerr_n;
            bus.ovf_err <= oerr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) mem[wr_spec[AW-1:0]] <= {weop, bus.data_in};
    end
endmodule

// File: tb/tb_datain_pkt_rx.sv
// tb_datain_pkt_rx: table of directed packets with hand-computed results, plus sequences for
// commit latency, back-pressure, overflow, back-to-back streaming and mid-packet reset.
module tb_datain_pkt_rx;
    typedef struct {
        string       name;
        int          n;
        logic [63:0] b;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0, nerr = 0;
    int n_ok = 0, n_pe = 0, n_le = 0, n_ov = 0;
    int s_ok, s_pe, s_le, s_ov;
    int t;
    logic [8:0] txq[$];
    logic [9:0] expq[$];
    vec_t tbl[8];

    datain_pkt_rx_if bus();
    datain_pkt_rx #(.DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_ok <= n_ok + 32'(bus.pkt_ok);
        n_pe <= n_pe + 32'(bus.parity_err);
        n_le <= n_le + 32'(bus.len_err);
        n_ov <= n_ov + 32'(bus.ovf_err);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic snap();
        s_ok = n_ok; s_pe = n_pe; s_le = n_le; s_ov = n_ov;
    endtask

    // pulse counts since snap(): {pkt_ok, parity_err, len_err, ovf_err}, one nibble each
    function automatic logic [15:0] pd();
        return {4'(n_ok - s_ok), 4'(n_pe - s_pe), 4'(n_le - s_le), 4'(n_ov - s_ov)};
    endfunction

    task automatic send_all();
        logic [8:0] e;
        while (txq.size() > 0) begin
            e = txq.pop_front();
            bus.packet_valid = e[8];
            bus.data_in = e[7:0];
            @(posedge clk); #1;
        end
        bus.packet_valid = 1'b0;
        bus.data_in = 8'd0;
    endtask

    task automatic load(input vec_t v);
        int l = int'(v.b[7:2]);
        for (int i = 0; i < v.n; i++) txq.push_back({1'b1, v.b[8*i +: 8]});
        if (v.exp == 16'h1000)
            for (int i = 0; i <= l; i++) expq.push_back({i == 0, i == l, v.b[8*i +: 8]});
    endtask

    task automatic fill(input logic [7:0] hdr, input logic [7:0] base, input bit good);
        logic [7:0] acc = hdr;
        logic [7:0] b;
        int l = int'(hdr[7:2]);
        txq.push_back({1'b1, hdr});
        if (good) expq.push_back({2'b10, hdr});
        for (int i = 1; i <= l; i++) begin
            b = base + 8'(i - 1);
            acc ^= b;
            txq.push_back({1'b1, b});
            if (good) expq.push_back({1'b0, i == l, b});
        end
        txq.push_back({1'b1, good ? acc : ~acc});
    endtask

    task automatic drain(input int n, input bit tog, output int cyc);
        int i = 0;
        int c = 0;
        logic [9:0] e;
        while (i < n && c < 500) begin
            bus.dout_ready = tog ? c[0] : 1'b1;
            if (bus.dout_valid && bus.dout_ready) begin
                e = expq.pop_front();
                chk("stream", {bus.dout_sop, bus.dout_eop, bus.dout}, e);
                i++;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.dout_ready = 1'b0;
        if (i < n) chk("drain_timeout", i, n);
        cyc = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"good_l3",   5, 64'h0D_33_22_11_0D,       16'h1000};
        tbl[1] = '{"parity",    5, 64'h00_33_22_11_0D,       16'h0100};
        tbl[2] = '{"good_l2",   4, 64'hF6_55_AA_09,          16'h1000};
        tbl[3] = '{"short",     3, 64'h22_11_0D,             16'h0010};
        tbl[4] = '{"long",      4, 64'h99_7B_7E_05,          16'h0010};
        tbl[5] = '{"len_zero",  2, 64'h02_02,                16'h0010};
        tbl[6] = '{"good_l1",   3, 64'hC4_C3_07,             16'h1000};
        tbl[7] = '{"good_l5",   7, 64'h15_05_04_03_02_01_14, 16'h1000};
        bus.packet_valid = 1'b0;
        bus.data_in = 8'd0;
        bus.dout_ready = 1'b0;
        idle(2);
        chk("reset_outputs", {bus.dout, bus.dout_valid, bus.dout_sop, bus.dout_eop, bus.pkt_ok,
            bus.parity_err, bus.len_err, bus.ovf_err, bus.busy}, 0);
        rst = 1'b0;
        idle(1);

        // commit latency and back-pressure hold
        load(tbl[0]);
        send_all();
        chk("pre_commit", {bus.pkt_ok, bus.dout_valid}, 0);
        idle(1);
        chk("commit", {bus.pkt_ok, bus.dout_valid, bus.dout_sop, bus.dout}, 11'h70D);
        idle(1);
        chk("hold", {bus.pkt_ok, bus.dout_valid, bus.dout_sop, bus.dout_eop, bus.dout}, 12'h60D);
        drain(4, 1'b0, t);
        chk("empty_a", bus.dout_valid, 0);

        foreach (tbl[k]) begin
            snap();
            load(tbl[k]);
            send_all();
            idle(3);
            chk({tbl[k].name, "_pulses"}, pd(), tbl[k].exp);
            drain(tbl[k].exp == 16'h1000 ? int'(tbl[k].b[7:2]) + 1 : 0, 1'b0, t);
            chk({tbl[k].name, "_empty"}, {bus.dout_valid, bus.busy}, 0);
        end

        // extra byte goes through DROP
        load(tbl[4]);
        send_all();
        chk("long_drop", {bus.len_err, bus.busy}, 2'b11);
        idle(1);
        chk("long_idle", {bus.len_err, bus.busy}, 0);

        // overflow: 41 entries held, L=30 rejected, L=22 fills exactly to 64
        snap();
        fill(8'hA0, 8'h01, 1'b1);
        send_all();
        idle(2);
        chk("ovf_first_ok", pd(), 16'h1000);
        snap();
        fill(8'h78, 8'h00, 1'b0);
        send_all();
        idle(2);
        chk("ovf_pulse", pd(), 16'h0001);
        snap();
        fill(8'h58, 8'h80, 1'b1);
        send_all();
        idle(2);
        chk("ovf_fit_ok", pd(), 16'h1000);
        drain(64, 1'b0, t);
        chk("no_bubble", t, 64);
        chk("empty_c", bus.dout_valid, 0);

        // back-to-back with one idle cycle while dout_ready toggles
        load(tbl[0]);
        txq.push_back(9'h000);
        load(tbl[7]);
        fork
            send_all();
            drain(10, 1'b1, t);
        join
        chk("empty_d", bus.dout_valid, 0);

        // reset mid-packet discards committed and speculative data
        load(tbl[2]);
        send_all();
        idle(1);
        chk("pre_reset_valid", bus.dout_valid, 1);
        expq.delete();
        bus.packet_valid = 1'b1;
        bus.data_in = 8'h0D;
        idle(1);
        bus.data_in = 8'h11;
        idle(1);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("async_reset", {bus.dout, bus.dout_valid, bus.dout_sop, bus.dout_eop, bus.pkt_ok,
            bus.parity_err, bus.len_err, bus.ovf_err, bus.busy}, 0);
        bus.packet_valid = 1'b0;
        bus.data_in = 8'd0;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("post_reset_empty", {bus.dout_valid, bus.busy}, 0);
        snap();
        load(tbl[6]);
        send_all();
        idle(2);
        chk("recover_ok", pd(), 16'h1000);
        drain(2, 1'b0, t);
        chk("empty_e", bus.dout_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
